dcache_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache; successor to the direct-mapped data cache.
- Sits between the shader load/store unit (request side) and the line-granular memory arbiter (memory side).
- Owns its own miss handling: victim selection, dirty write-back and refill, so the caller no longer sequences ejects.
- Partial (8/16/32-bit) writes are merged into the resident line (true read-modify-write).

---
 rtl/dcache_assoc.sv | 216 +++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache.
// Handles its own misses: victim choice, dirty write-back and line refill.

typedef enum logic [1:0] {
    SizeB8  = 2'd0,
    SizeB16 = 2'd1,
    SizeB32 = 2'd2,
    SizeB64 = 2'd3
} dcache_data_size_e;

module dcache_assoc #(
    parameter int unsigned addr_width      = 16,
    parameter int unsigned line_width      = 64,
    parameter int unsigned sets            = 16,
    parameter int unsigned ways            = 2,
    parameter int unsigned offset_width    = $clog2(line_width / 8),
    parameter int unsigned index_width     = $clog2(sets),
    parameter int unsigned line_addr_width = addr_width - offset_width,
    parameter int unsigned tag_width       = line_addr_width - index_width
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [addr_width-1:0]      req_addr_i,
    input  dcache_data_size_e          req_size_i,
    input  logic [63:0]                req_wdata_i,
    output logic                       resp_valid_o,
    output logic [63:0]                resp_data_o,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic                       mem_req_write_o,
    output logic [line_addr_width-1:0] mem_req_addr_o,
    output logic [line_width-1:0]      mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic [line_width-1:0]      mem_rdata_i
);

    // A 1-bit pointer is kept for ways == 1; it simply never advances.
    localparam int unsigned way_w = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic [2:0] {
        StIdle, StLookup, StWriteback, StRefillReq, StRefillWait
    } state_e;

    state_e                     state_q;
    logic [sets-1:0]            valid_q [ways];
    logic [sets-1:0]            dirty_q [ways];
    logic [tag_width-1:0]       tag_q   [ways][sets];
    logic [line_width-1:0]      data_q  [ways][sets];
    logic [way_w-1:0]           ptr_q   [sets];

    logic                       req_write_q;
    logic [addr_width-1:0]      req_addr_q;
    dcache_data_size_e          req_size_q;
    logic [63:0]                req_wdata_q;
    logic [way_w-1:0]           victim_q;
    logic                       victim_valid_q;

    logic                       req_ready_q, resp_valid_q, mem_req_valid_q, mem_req_write_q;
    logic [63:0]                resp_data_q;
    logic [line_addr_width-1:0] mem_req_addr_q;
    logic [line_width-1:0]      mem_wdata_q;

    logic [index_width-1:0]     req_idx;
    logic [tag_width-1:0]       req_tag;
    logic [line_addr_width-1:0] req_line;

    assign req_idx  = req_addr_q[offset_width +: index_width];
    assign req_tag  = req_addr_q[addr_width-1 -: tag_width];
    assign req_line = req_addr_q[addr_width-1 -: line_addr_width];

    logic                       hit, inv_found;
    logic [way_w-1:0]           hit_way, victim_way;

    // Tag compare across the latched set and victim choice (lowest invalid, else pointer).
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        victim_way = ptr_q[req_idx];
        for (int w = 0; w < ways; w++) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = way_w'(w);
            end
            if (!valid_q[w][req_idx] && !inv_found) begin
                inv_found  = 1'b1;
                victim_way = way_w'(w);
            end
        end
    end

    logic [offset_width-1:0]    low_bits, off_al;
    logic [offset_width+2:0]    shamt;
    logic [63:0]                size_bits, rd_lane;
    logic [line_width-1:0]      hit_line, wr_mask, merged;

    // Size-aligned lane extraction and read-modify-write merge for the hit line.
    always_comb begin
        low_bits = offset_width'((32'd1 << req_size_q) - 32'd1);
        off_al   = req_addr_q[offset_width-1:0] & ~low_bits;
        shamt    = {off_al, 3'b000};
        case (req_size_q)
            SizeB8:  size_bits = 64'h0000_0000_0000_00FF;
            SizeB16: size_bits = 64'h0000_0000_0000_FFFF;
            SizeB32: size_bits = 64'h0000_0000_FFFF_FFFF;
            default: size_bits = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        hit_line = data_q[hit_way][req_idx];
        rd_lane  = 64'(hit_line >> shamt) & size_bits;
        wr_mask  = line_width'(size_bits) << shamt;
        merged   = (hit_line & ~wr_mask) | (line_width'(req_wdata_q & size_bits) << shamt);
    end

    // Controller FSM with registered outputs; also owns all array updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_wdata_q     <= '0;
            for (int w = 0; w < ways; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < sets; s++) ptr_q[s] <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        req_write_q <= req_write_i;
                        req_addr_q  <= req_addr_i;
                        req_size_q  <= req_size_i;
                        req_wdata_q <= req_wdata_i;
                        req_ready_q <= 1'b0;
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        resp_valid_q <= 1'b1;
                        if (req_write_q) begin
                            data_q[hit_way][req_idx]  <= merged;
                            dirty_q[hit_way][req_idx] <= 1'b1;
                        end else begin
                            resp_data_q <= rd_lane;
                        end
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        victim_q        <= victim_way;
                        victim_valid_q  <= valid_q[victim_way][req_idx];
                        mem_req_valid_q <= 1'b1;
                        if (valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx]) begin
                            mem_req_write_q <= 1'b1;
                            mem_req_addr_q  <= {tag_q[victim_way][req_idx], req_idx};
                            mem_wdata_q     <= data_q[victim_way][req_idx];
                            state_q         <= StWriteback;
                        end else begin
                            mem_req_write_q <= 1'b0;
                            mem_req_addr_q  <= req_line;
                            mem_wdata_q     <= '0;
                            state_q         <= StRefillReq;
                        end
                    end
                end
                StWriteback: begin
                    if (mem_req_ready_i) begin
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= req_line;
                        mem_wdata_q     <= '0;
                        state_q         <= StRefillReq;
                    end
                end
                StRefillReq: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= StRefillWait;
                    end
                end
                StRefillWait: begin
                    if (mem_rvalid_i) begin
                        data_q[victim_q][req_idx]  <= mem_rdata_i;
                        tag_q[victim_q][req_idx]   <= req_tag;
                        valid_q[victim_q][req_idx] <= 1'b1;
                        dirty_q[victim_q][req_idx] <= 1'b0;
                        if (victim_valid_q) begin
                            ptr_q[req_idx] <= (ptr_q[req_idx] == way_w'(ways - 1)) ?
                                              '0 : ptr_q[req_idx] + 1'b1;
                        end
                        state_q <= StLookup;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_data_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_write_o = mem_req_write_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    assign mem_wdata_o     = mem_wdata_q;

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (4 sets, 2 ways, 64-bit lines) with response
// and memory-request scoreboards.

module tb_dcache_assoc;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [15:0]       req_addr;
    dcache_data_size_e req_size;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_data;
    logic              mem_req_valid, mem_req_ready, mem_req_write;
    logic [13:0]       mem_req_addr;
    logic [63:0]       mem_wdata;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    dcache_assoc #(
        .addr_width (16),
        .line_width (64),
        .sets       (4),
        .ways       (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_size_i      (req_size),
        .req_wdata_i     (req_wdata),
        .resp_valid_o    (resp_valid),
        .resp_data_o     (resp_data),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_write_o (mem_req_write),
        .mem_req_addr_o  (mem_req_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [13:0] a;
        logic [63:0] d;
    } mreq_t;

    logic [63:0] exp_resp[$];
    mreq_t       exp_mem[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int resp_cyc = 0;
    int mem_hs = 0;
    int rd_hs = 0;
    int acc_cyc = 0;
    int nr = 0;
    int nrd = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pops expected responses and memory requests.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            resp_cyc = cyc;
            check("resp_expected", 64'(exp_resp.size() != 0), 64'd1);
            if (exp_resp.size() != 0) check("resp_data", resp_data, exp_resp.pop_front());
        end
        if (mem_req_valid && mem_req_ready) begin
            mreq_t e;
            mem_hs++;
            if (!mem_req_write) rd_hs++;
            check("mem_expected", 64'(exp_mem.size() != 0), 64'd1);
            if (exp_mem.size() != 0) begin
                e = exp_mem.pop_front();
                check("mem_write", 64'(mem_req_write), 64'(e.w));
                check("mem_addr", 64'(mem_req_addr), 64'(e.a));
                if (e.w) check("mem_wdata", mem_wdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [15:0] a, input dcache_data_size_e s,
                        input logic [63:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                check("req_accept", 64'(req_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n = 0;
        while (resp_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("resp_arrived", 64'(resp_cnt >= target), 64'd1);
        #1;
    endtask

    task automatic wait_rd(input int target);
        int n = 0;
        while (rd_hs < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("refill_req_seen", 64'(rd_hs >= target), 64'd1);
        #1;
    endtask

    task automatic pulse_rvalid(input logic [63:0] data, input int lat);
        repeat (lat) tick();
        mem_rdata  = data;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic        h_w;
        logic [13:0] h_a;
        logic [63:0] h_d;
        int          n;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = SizeB8;
        req_wdata = '0; mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_write", 64'(mem_req_write), 64'd0);
        check("rst_mem_addr", 64'(mem_req_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // Cold miss, 32-bit load.
        exp_mem.push_back('{w: 1'b0, a: 14'h2, d: 64'h0});
        exp_resp.push_back(64'h0000_0000_5566_7788);
        send(1'b0, 16'h0010, SizeB32, 64'h0);
        nrd++; wait_rd(nrd);
        pulse_rvalid(64'h1122_3344_5566_7788, 2);
        nr++; wait_resp(nr);
        check("cold_miss_mem_hs", 64'(mem_hs), 64'd1);

        // Byte store hit, then 64-bit load hit.
        exp_resp.push_back(64'h0);
        send(1'b1, 16'h0013, SizeB8, 64'hFFFF_FFFF_FFFF_FFAB);
        nr++; wait_resp(nr);
        check("store_hit_latency", 64'(resp_cyc), 64'(acc_cyc + 1));
        exp_resp.push_back(64'h1122_3344_AB66_7788);
        send(1'b0, 16'h0010, SizeB64, 64'h0);
        nr++; wait_resp(nr);
        check("load_hit_latency", 64'(resp_cyc), 64'(acc_cyc + 1));
        check("hits_no_mem", 64'(mem_hs), 64'd1);

        // Fill way 1, then evict dirty way 0.
        exp_mem.push_back('{w: 1'b0, a: 14'h6, d: 64'h0});
        exp_resp.push_back(64'h3030_3030_0000_0030);
        send(1'b0, 16'h0030, SizeB64, 64'h0);
        nrd++; wait_rd(nrd);
        pulse_rvalid(64'h3030_3030_0000_0030, 0);
        nr++; wait_resp(nr);
        exp_mem.push_back('{w: 1'b1, a: 14'h2, d: 64'h1122_3344_AB66_7788});
        exp_mem.push_back('{w: 1'b0, a: 14'hA, d: 64'h0});
        exp_resp.push_back(64'hA5A5_0000_1234_5678);
        send(1'b0, 16'h0050, SizeB64, 64'h0);
        nrd++; wait_rd(nrd);
        pulse_rvalid(64'hA5A5_0000_1234_5678, 1);
        nr++; wait_resp(nr);
        check("dirty_evict_mem_hs", 64'(mem_hs), 64'd4);

        // Clean eviction of way 1 (pointer now 1), 16-bit load at offset 6.
        exp_mem.push_back('{w: 1'b0, a: 14'hE, d: 64'h0});
        exp_resp.push_back(64'h0000_0000_0000_0F0E);
        send(1'b0, 16'h0076, SizeB16, 64'h0);
        nrd++; wait_rd(nrd);
        pulse_rvalid(64'h0F0E_0D0C_0B0A_0908, 0);
        nr++; wait_resp(nr);
        check("clean_evict_mem_hs", 64'(mem_hs), 64'd5);
        exp_resp.push_back(64'hA5A5_0000_1234_5678);
        send(1'b0, 16'h0050, SizeB64, 64'h0);
        nr++; wait_resp(nr);
        check("way0_kept_latency", 64'(resp_cyc), 64'(acc_cyc + 1));
        check("way0_kept_mem_hs", 64'(mem_hs), 64'd5);

        // Dirty way 0 again, then stall the write-back for 5 cycles.
        exp_resp.push_back(64'h0);
        send(1'b1, 16'h0050, SizeB16, 64'h0000_0000_0000_BEEF);
        nr++; wait_resp(nr);
        mem_req_ready = 1'b0;
        exp_mem.push_back('{w: 1'b1, a: 14'hA, d: 64'hA5A5_0000_1234_BEEF});
        exp_mem.push_back('{w: 1'b0, a: 14'h2, d: 64'h0});
        exp_resp.push_back(64'h0000_0000_CAFE_F00D);
        send(1'b0, 16'h0014, SizeB32, 64'h0);
        n = 0;
        while (!mem_req_valid && n < 50) begin
            tick();
            n++;
        end
        check("wb_valid", 64'(mem_req_valid), 64'd1);
        h_w = mem_req_write; h_a = mem_req_addr; h_d = mem_wdata;
        check("wb_write", 64'(h_w), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(mem_req_valid), 64'd1);
            check("hold_write", 64'(mem_req_write), 64'(h_w));
            check("hold_addr", 64'(mem_req_addr), 64'(h_a));
            check("hold_wdata", mem_wdata, h_d);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_resp_valid", 64'(resp_valid), 64'd0);
        end
        mem_req_ready = 1'b1;
        nrd++; wait_rd(nrd);
        pulse_rvalid(64'hCAFE_F00D_DEAD_BEEF, 0);
        nr++; wait_resp(nr);

        // Reset while waiting for refill; the late rvalid must be ignored.
        exp_mem.push_back('{w: 1'b0, a: 14'h6, d: 64'h0});
        send(1'b0, 16'h0030, SizeB64, 64'h0);
        nrd++; wait_rd(nrd);
        rst = 1'b1;
        tick();
        tick();
        check("abort_rst_ready", 64'(req_ready), 64'd0);
        check("abort_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        rst = 1'b0;
        pulse_rvalid(64'h0BAD_0BAD_0BAD_0BAD, 0);
        repeat (4) tick();
        check("abort_no_resp", 64'(resp_cnt), 64'(nr));
        exp_mem.push_back('{w: 1'b0, a: 14'h2, d: 64'h0});
        exp_resp.push_back(64'h0000_0000_7777_6666);
        send(1'b0, 16'h0010, SizeB32, 64'h0);
        nrd++; wait_rd(nrd);
        pulse_rvalid(64'h5555_4444_7777_6666, 1);
        nr++; wait_resp(nr);

        repeat (3) tick();
        check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
        check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        check("total_resps", 64'(resp_cnt), 64'(nr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
